lut_scan_ctrl: RTL and testbench

//  Upstream sequencer for the tile-code LUT. On start it walks bank A (add 0..15)
//  and then bank B (bdd 0..8). It drives the LUT's select codes and addresses,

---
 rtl/lut_scan_pkg.sv | 20 ++
 rtl/lut_scan_ctrl.sv | 110 +++++++++++
 tb/tb_lut_scan_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_scan_pkg.sv
// rtl/lut_scan_pkg.sv - shared state encoding and constants for the tile-code LUT scan sequencer
package lut_scan_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_RD  = 3'd1,
        A_OUT = 3'd2,
        B_RD  = 3'd3,
        B_OUT = 3'd4,
        DONE  = 3'd5
    } scan_state_t;

    localparam logic [1:0] RW_READ = 2'b10;
    localparam logic [1:0] RW_IDLE = 2'b00;

    localparam int A_DEPTH_DEF = 16;
    localparam int B_DEPTH_DEF = 9;
    localparam int CODE_W_DEF  = 8;

endpackage

// File: rtl/lut_scan_ctrl.sv
// rtl/lut_scan_ctrl.sv - walks LUT bank A then bank B and streams every returned code downstream
module lut_scan_ctrl
    import lut_scan_pkg::*;
#(
    parameter int A_DEPTH = A_DEPTH_DEF,
    parameter int B_DEPTH = B_DEPTH_DEF,
    parameter int CODE_W  = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [1:0]        arw,
    output logic [1:0]        brw,
    output logic [4:0]        add,
    output logic [4:0]        bdd,
    input  logic [CODE_W-1:0] z_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bank,
    output logic [4:0]        out_idx,
    output logic [CODE_W-1:0] out_code,
    output logic              busy,
    output logic              done
);

    scan_state_t       state, state_n;
    logic [4:0]        idx, idx_n;
    logic              cap;
    logic              bank_n;
    logic [4:0]        oidx_n;
    logic [CODE_W-1:0] code_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = A_RD;
                    idx_n   = 5'd0;
                end
            end
            A_RD: state_n = A_OUT;
            A_OUT: begin
                if (out_valid && out_ready) begin
                    if (idx == 5'(A_DEPTH - 1)) begin
                        state_n = B_RD;
                        idx_n   = 5'd0;
                    end else begin
                        state_n = A_RD;
                        idx_n   = idx + 5'd1;
                    end
                end
            end
            B_RD: state_n = B_OUT;
            B_OUT: begin
                if (out_valid && out_ready) begin
                    if (idx == 5'(B_DEPTH - 1)) begin
                        state_n = DONE;
                    end else begin
                        state_n = B_RD;
                        idx_n   = idx + 5'd1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The LUT answers combinationally during a read cycle, so the code is taken at the end of it.
    always_comb begin
        cap    = (state == A_RD) || (state == B_RD);
        code_n = cap ? z_in : out_code;
        bank_n = cap ? (state == B_RD) : out_bank;
        oidx_n = cap ? idx : out_idx;
    end

    // All outputs are decoded from the next state so they appear registered in the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 5'd0;
            arw       <= RW_IDLE;
            brw       <= RW_IDLE;
            add       <= 5'd0;
            bdd       <= 5'd0;
            out_valid <= 1'b0;
            out_bank  <= 1'b0;
            out_idx   <= 5'd0;
            out_code  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            arw       <= (state_n == A_RD) ? RW_READ : RW_IDLE;
            brw       <= (state_n == B_RD) ? RW_READ : RW_IDLE;
            add       <= (state_n == A_RD) ? {1'b0, idx_n[3:0]} : 5'd0;
            bdd       <= (state_n == B_RD) ? {1'b0, idx_n[3:0]} : 5'd0;
            out_valid <= (state_n == A_OUT) || (state_n == B_OUT);
            out_bank  <= bank_n;
            out_idx   <= oidx_n;
            out_code  <= code_n;
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_lut_scan_ctrl.sv
// tb/tb_lut_scan_ctrl.sv - self-checking bench for lut_scan_ctrl with a behavioural tile-code LUT
module tb_lut_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] arw, brw;
    logic [4:0] add, bdd;
    logic [7:0] z_in;
    logic       out_valid, out_ready, out_bank;
    logic [4:0] out_idx;
    logic [7:0] out_code;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    logic [7:0] lut_a [16] = '{8'd3, 8'd5, 8'd0, 8'd1, 8'd4, 8'd0, 8'd6, 8'd4,
                               8'd4, 8'd6, 8'd0, 8'd4, 8'd1, 8'd0, 8'd5, 8'd3};
    logic [7:0] lut_b [16] = '{8'd1, 8'd3, 8'd1, 8'd0, 8'd5, 8'd0, 8'd1, 8'd3,
                               8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    // Beats recorded by the last scan
    int beat_bank [$];
    int beat_idx  [$];
    int beat_code [$];
    int beat_cyc  [$];
    int done_cnt, done_cyc, idle_cyc;
    bit timed_out;

    always #5 clk = ~clk;

    // Tile-code LUT: bank A has priority when both selects read
    always_comb begin
        z_in = 8'd0;
        if (arw == 2'b10)      z_in = lut_a[add[3:0]];
        else if (brw == 2'b10) z_in = lut_b[bdd[3:0]];
    end

    lut_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .arw       (arw),
        .brw       (brw),
        .add       (add),
        .bdd       (bdd),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bank  (out_bank),
        .out_idx   (out_idx),
        .out_code  (out_code),
        .busy      (busy),
        .done      (done)
    );

    // Element k of a full scan: bank A entries 0..15, then bank B entries 0..8
    function automatic int exp_bank(int k);
        return (k < 16) ? 0 : 1;
    endfunction
    function automatic int exp_idx(int k);
        return (k < 16) ? k : k - 16;
    endfunction
    function automatic int exp_code(int k);
        return (k < 16) ? int'(lut_a[k]) : int'(lut_b[k - 16]);
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (arw === 2'b10 && brw === 2'b10) begin
                errors++;
                $display("FAIL select_overlap got arw=%b brw=%b want not both 10", arw, brw);
            end
            checks++;
            if (add[4] !== 1'b0 || bdd[4] !== 1'b0) begin
                errors++;
                $display("FAIL addr_bit4 got add=%b bdd=%b want bit4=0", add, bdd);
            end
        end
    end

    // Runs one scan from a start pulse in cycle 0 and records what streams out.
    task automatic do_scan(input bit rnd_ready, input bit restart_at_b4);
        beat_bank.delete(); beat_idx.delete(); beat_code.delete(); beat_cyc.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; timed_out = 1'b1;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c > 1 && !busy) begin
                idle_cyc = c;
                timed_out = 1'b0;
                break;
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                beat_bank.push_back(int'(out_bank));
                beat_idx.push_back(int'(out_idx));
                beat_code.push_back(int'(out_code));
                beat_cyc.push_back(c);
                if (restart_at_b4 && out_bank && out_idx == 5'd4) start = 1'b1;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({arw, brw, add, bdd, out_valid, out_bank, out_idx, out_code, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got arw=%b brw=%b add=%0d bdd=%0d v=%b bank=%b idx=%0d code=%0d busy=%b done=%b want all 0",
                     arw, brw, add, bdd, out_valid, out_bank, out_idx, out_code, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_scan;
        do_scan(1'b0, 1'b0);
        checks++;
        if (timed_out || beat_code.size() != 25) begin
            errors++;
            $display("FAIL full_beats got %0d (timeout=%0d) want 25", beat_code.size(), timed_out);
        end
        for (int k = 0; k < 25 && k < beat_code.size(); k++) begin
            checks++;
            if (beat_bank[k] != exp_bank(k) || beat_idx[k] != exp_idx(k) ||
                beat_code[k] != exp_code(k) || beat_cyc[k] != 2 * k + 2) begin
                errors++;
                $display("FAIL full_beat%0d got bank=%0d idx=%0d code=%0d cyc=%0d want bank=%0d idx=%0d code=%0d cyc=%0d",
                         k, beat_bank[k], beat_idx[k], beat_code[k], beat_cyc[k],
                         exp_bank(k), exp_idx(k), exp_code(k), 2 * k + 2);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 51 || idle_cyc != 52) begin
            errors++;
            $display("FAIL full_done got cnt=%0d cyc=%0d idle=%0d want cnt=1 cyc=51 idle=52",
                     done_cnt, done_cyc, idle_cyc);
        end
    endtask

    task automatic test_backpressure;
        bit found;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && !out_bank && out_idx == 5'd6) begin
                found = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_reach_a6 got none want A idx 6 beat");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 5'd6 || out_code !== 8'd6 || out_bank !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b bank=%b idx=%0d code=%0d want v=1 bank=0 idx=6 code=6",
                         i, out_valid, out_bank, out_idx, out_code);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || out_idx !== 5'd7 || out_code !== 8'd4 || out_bank !== 1'b0) begin
            errors++;
            $display("FAIL bp_next got found=%0d bank=%b idx=%0d code=%0d want bank=0 idx=7 code=4",
                     found, out_bank, out_idx, out_code);
        end
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_drain got busy=%b want 0", busy);
        end
    endtask

    task automatic test_restart_ignored;
        do_scan(1'b0, 1'b1);
        checks++;
        if (timed_out || beat_code.size() != 25 || done_cnt != 1) begin
            errors++;
            $display("FAIL restart_scan got beats=%0d done=%0d timeout=%0d want beats=25 done=1",
                     beat_code.size(), done_cnt, timed_out);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL restart_queued got busy=%b v=%b want 0 0", busy, out_valid);
            end
        end
    endtask

    task automatic test_random_ready;
        for (int r = 0; r < 2; r++) begin
            do_scan(1'b1, 1'b0);
            checks++;
            if (timed_out || beat_code.size() != 25 || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_scan got beats=%0d done=%0d timeout=%0d want beats=25 done=1",
                         r, beat_code.size(), done_cnt, timed_out);
            end
            for (int k = 0; k < 25 && k < beat_code.size(); k++) begin
                checks++;
                if (beat_bank[k] != exp_bank(k) || beat_idx[k] != exp_idx(k) || beat_code[k] != exp_code(k)) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d got bank=%0d idx=%0d code=%0d want bank=%0d idx=%0d code=%0d",
                             r, k, beat_bank[k], beat_idx[k], beat_code[k], exp_bank(k), exp_idx(k), exp_code(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_bank && out_idx == 5'd2) begin
                found = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reach_b2 got none want B idx 2 beat");
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_code !== 8'd0 ||
            out_idx !== 5'd0 || brw !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset got v=%b busy=%b done=%b code=%0d idx=%0d brw=%b want all 0",
                     out_valid, busy, done, out_code, out_idx, brw);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_quiet%0d got done=%b v=%b want 0 0", i, done, out_valid);
            end
        end
        do_scan(1'b0, 1'b0);
        checks++;
        if (timed_out || beat_code.size() != 25 || done_cnt != 1) begin
            errors++;
            $display("FAIL mid_rescan got beats=%0d done=%0d want beats=25 done=1", beat_code.size(), done_cnt);
        end
        for (int k = 0; k < 25 && k < beat_code.size(); k++) begin
            checks++;
            if (beat_bank[k] != exp_bank(k) || beat_idx[k] != exp_idx(k) || beat_code[k] != exp_code(k)) begin
                errors++;
                $display("FAIL mid_beat%0d got bank=%0d idx=%0d code=%0d want bank=%0d idx=%0d code=%0d",
                         k, beat_bank[k], beat_idx[k], beat_code[k], exp_bank(k), exp_idx(k), exp_code(k));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        test_reset;
        test_full_scan;
        test_backpressure;
        test_restart_ignored;
        test_random_ready;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
